// File: rtl/ps2_kbmat.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbmat
// Brief    : PS/2 keyboard receiver and scancode decoder driving a 64-bit
//            Z88 key matrix (1 = pressed, index = row*8 + col).
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbmat #(
    parameter int TMO_BITS = 13,
    parameter int EXT_EN   = 1
) (
    input  logic        mck,
    input  logic        rin_n,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [63:0] kbmat,
    output logic        kb_err,
    output logic        kb_vld,
    output logic [7:0]  kb_byte
);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {DEC_NORM, DEC_BRK, DEC_EXT, DEC_EXTBRK} dec_state_t;

    localparam logic [7:0] c_code_ext = 8'hE0;
    localparam logic [7:0] c_code_brk = 8'hF0;
    localparam logic [7:0] c_code_bat = 8'hAA;

    // ------------------------------------------------------------------
    // Synchronisers and falling-edge detect on the PS/2 clock
    // ------------------------------------------------------------------
    logic r_clk_s1, r_clk_s2, r_clk_prev;
    logic r_dat_s1, r_dat_s2;
    logic w_fall;

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_dat;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_s2;

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    rx_state_t           r_rx_state, w_rx_next;
    logic [2:0]          r_bit_cnt, w_bit_cnt_next;
    logic [7:0]          r_shift, w_shift_next;
    logic                r_par, w_par_next;
    logic [TMO_BITS-1:0] r_tmo, w_tmo_next;
    logic                w_tmo_wrap, w_vld_next, w_err_next;
    logic                r_kb_vld, r_kb_err;
    logic [7:0]          r_kb_byte;

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            r_rx_state <= RX_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_par      <= 1'b0;
            r_tmo      <= '0;
            r_kb_vld   <= 1'b0;
            r_kb_err   <= 1'b0;
            r_kb_byte  <= 8'h00;
        end else begin
            r_rx_state <= w_rx_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_par      <= w_par_next;
            r_tmo      <= w_tmo_next;
            r_kb_vld   <= w_vld_next;
            r_kb_err   <= w_err_next;
            if (w_vld_next) begin
                r_kb_byte <= r_shift;
            end
        end
    end

    // The counter wraps to zero by itself; the wrap also aborts the frame.
    assign w_tmo_wrap = (r_rx_state != RX_IDLE) && !w_fall && (&r_tmo);

    always_comb begin
        w_rx_next      = r_rx_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_par_next     = r_par;
        w_vld_next     = 1'b0;
        w_err_next     = 1'b0;
        w_tmo_next     = (w_fall || r_rx_state == RX_IDLE) ? '0 : r_tmo + 1'b1;

        if (w_tmo_wrap) begin
            w_rx_next  = RX_IDLE;
            w_err_next = 1'b1;
        end else if (w_fall) begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_dat_s2) begin
                        w_rx_next      = RX_DATA;
                        w_bit_cnt_next = 3'd0;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
                RX_DATA: begin
                    w_shift_next   = {r_dat_s2, r_shift[7:1]};
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_rx_next = RX_PAR;
                    end
                end
                RX_PAR: begin
                    w_par_next = r_dat_s2;
                    w_rx_next  = RX_STOP;
                end
                default: begin
                    if (r_dat_s2 && (^{r_shift, r_par})) begin
                        w_vld_next = 1'b1;
                    end else begin
                        w_err_next = 1'b1;
                    end
                    w_rx_next = RX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scancode decoder and key matrix
    // ------------------------------------------------------------------
    dec_state_t  r_dec_state, w_dec_next;
    logic [63:0] r_kbmat;
    logic [6:0]  w_map;
    logic        w_ext_sel, w_km_set, w_km_clr, w_km_clr_all;

    assign w_ext_sel = (r_dec_state == DEC_EXT) || (r_dec_state == DEC_EXTBRK);

    // Bit 6 set marks an unmapped code.
    always_comb begin
        w_map = 7'h40;
        if (w_ext_sel) begin
            case (r_kb_byte)
                8'h75:   w_map = 7'd3;
                8'h6B:   w_map = 7'd4;
                default: w_map = 7'h40;
            endcase
        end else begin
            case (r_kb_byte)
                8'h5A:   w_map = 7'd6;
                8'h1C:   w_map = 7'd45;
                8'h29:   w_map = 7'd53;
                8'h12:   w_map = 7'd54;
                8'h59:   w_map = 7'd63;
                default: w_map = 7'h40;
            endcase
        end
    end

    always_comb begin
        w_dec_next   = r_dec_state;
        w_km_set     = 1'b0;
        w_km_clr     = 1'b0;
        w_km_clr_all = 1'b0;
        if (r_kb_vld) begin
            if (r_kb_byte == c_code_bat) begin
                w_km_clr_all = 1'b1;
                w_dec_next   = DEC_NORM;
            end else if (r_kb_byte == c_code_ext) begin
                if (EXT_EN != 0) begin
                    if (r_dec_state == DEC_NORM) w_dec_next = DEC_EXT;
                    if (r_dec_state == DEC_BRK)  w_dec_next = DEC_EXTBRK;
                end
            end else if (r_kb_byte == c_code_brk) begin
                if (r_dec_state == DEC_NORM) w_dec_next = DEC_BRK;
                if (r_dec_state == DEC_EXT)  w_dec_next = DEC_EXTBRK;
            end else begin
                w_dec_next = DEC_NORM;
                if (!w_map[6]) begin
                    if (r_dec_state == DEC_BRK || r_dec_state == DEC_EXTBRK) begin
                        w_km_clr = 1'b1;
                    end else begin
                        w_km_set = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            r_dec_state <= DEC_NORM;
            r_kbmat     <= 64'd0;
        end else begin
            r_dec_state <= w_dec_next;
            if (w_km_clr_all) begin
                r_kbmat <= 64'd0;
            end else if (w_km_set) begin
                r_kbmat[w_map[5:0]] <= 1'b1;
            end else if (w_km_clr) begin
                r_kbmat[w_map[5:0]] <= 1'b0;
            end
        end
    end

    assign kbmat   = r_kbmat;
    assign kb_err  = r_kb_err;
    assign kb_vld  = r_kb_vld;
    assign kb_byte = r_kb_byte;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbmat.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbmat
// Brief    : Directed self-checking bench for ps2_kbmat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kbmat;

    localparam int c_half = 20;

    logic        mck = 1'b0;
    logic        rin_n;
    logic        ps2_clk;
    logic        ps2_dat;
    logic [63:0] kbmat;
    logic        kb_err;
    logic        kb_vld;
    logic [7:0]  kb_byte;

    int n_checks = 0;
    int n_errors = 0;

    always #50 mck = ~mck;

    ps2_kbmat #(.TMO_BITS(13), .EXT_EN(1)) u_dut (
        .mck     (mck),
        .rin_n   (rin_n),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .kbmat   (kbmat),
        .kb_err  (kb_err),
        .kb_vld  (kb_vld),
        .kb_byte (kb_byte)
    );

    // Pulse monitor: counts high cycles and captures kbmat at and after kb_vld
    int          vld_cnt = 0;
    int          err_cnt = 0;
    logic [63:0] km_at_vld = '0;
    logic [63:0] km_after  = '0;
    bit          pend = 1'b0;

    always @(negedge mck) begin
        if (rin_n) begin
            if (kb_err) err_cnt++;
            if (kb_vld) begin
                vld_cnt++;
                km_at_vld = kbmat;
                pend = 1'b1;
            end else if (pend) begin
                km_after = kbmat;
                pend = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        repeat (c_half) @(posedge mck);
        ps2_clk = 1'b0;
        repeat (c_half) @(posedge mck);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ flip);
        send_bit(1'b1);
        repeat (c_half) @(posedge mck);
    endtask

    task automatic good_frame(input logic [7:0] b, input logic [63:0] exp_km);
        int          v0 = vld_cnt;
        int          e0 = err_cnt;
        logic [63:0] km0 = kbmat;
        send_frame(b, 1'b0);
        check_eq($sformatf("vld_pulse_%h", b), 64'(vld_cnt - v0), 64'd1);
        check_eq($sformatf("no_err_%h", b), 64'(err_cnt - e0), 64'd0);
        check_eq($sformatf("kb_byte_%h", b), 64'(kb_byte), 64'(b));
        check_eq($sformatf("km_at_vld_%h", b), km_at_vld, km0);
        check_eq($sformatf("km_after_%h", b), km_after, exp_km);
    endtask

    initial begin
        logic [63:0] km;
        int          v0;
        int          e0;

        rin_n   = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(negedge mck);
        check_eq("rst_kbmat", kbmat, 64'd0);
        check_eq("rst_vld", 64'(kb_vld), 64'd0);
        check_eq("rst_err", 64'(kb_err), 64'd0);
        check_eq("rst_byte", 64'(kb_byte), 64'd0);
        rin_n = 1'b1;
        repeat (5) @(posedge mck);

        // Falling edge with data high is not a start bit
        e0 = err_cnt;
        send_bit(1'b1);
        repeat (5) @(posedge mck);
        check_eq("stray_start_err", 64'(err_cnt - e0), 64'd1);

        km = 64'd1 << 45;
        good_frame(8'h1C, km);
        good_frame(8'hF0, km);
        km = 64'd0;
        good_frame(8'h1C, km);

        good_frame(8'hE0, km);
        km = 64'd1 << 3;
        good_frame(8'h75, km);
        good_frame(8'hE0, km);
        good_frame(8'hF0, km);
        km = 64'd0;
        good_frame(8'h75, km);

        // Bad parity
        v0 = vld_cnt;
        e0 = err_cnt;
        send_frame(8'h5A, 1'b1);
        check_eq("badpar_err", 64'(err_cnt - e0), 64'd1);
        check_eq("badpar_vld", 64'(vld_cnt - v0), 64'd0);
        check_eq("badpar_km", kbmat, km);
        check_eq("badpar_byte", 64'(kb_byte), 64'h75);

        // Typematic repeat, unmapped byte, break of unpressed key
        km = 64'd1 << 6;
        good_frame(8'h5A, km);
        good_frame(8'h5A, km);
        good_frame(8'hE1, km);
        good_frame(8'hF0, km);
        good_frame(8'h29, km);

        // Truncated frame followed by a long idle line
        v0 = vld_cnt;
        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat ((1 << 13) + 10) @(posedge mck);
        check_eq("tmo_err", 64'(err_cnt - e0), 64'd1);
        check_eq("tmo_vld", 64'(vld_cnt - v0), 64'd0);
        check_eq("tmo_km", kbmat, km);
        km = km | (64'd1 << 53);
        good_frame(8'h29, km);

        km = km | (64'd1 << 54);
        good_frame(8'h12, km);
        km = km | (64'd1 << 63);
        good_frame(8'h59, km);
        km = 64'd0;
        good_frame(8'hAA, km);

        // Reset in the middle of a frame
        km = 64'd1 << 45;
        good_frame(8'h1C, km);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        @(negedge mck);
        #7 rin_n = 1'b0;
        #1;
        check_eq("midrst_kbmat", kbmat, 64'd0);
        check_eq("midrst_vld", 64'(kb_vld), 64'd0);
        check_eq("midrst_byte", 64'(kb_byte), 64'd0);
        ps2_dat = 1'b1;
        repeat (4) @(posedge mck);
        rin_n = 1'b1;
        repeat (5) @(posedge mck);
        km = 64'd1 << 6;
        good_frame(8'h5A, km);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_kbmat.md
PS2_KBMAT -- requirements
Module: ps2_kbmat

Interface
REQ-001 Parameter TMO_BITS, default 13, sets the mid-frame inactivity timeout to 2^TMO_BITS mck cycles.
REQ-002 Parameter EXT_EN, default 1; when 1, E0-prefixed codes use the extended map, and when 0 the E0 prefix is ignored.
REQ-003 mck  input  1  9.83MHz master clock; the block has one clock; all flops are on posedge mck.
REQ-004 rin_n  input  1  reset, asynchronous, active-low.
REQ-005 ps2_clk  input  1  PS/2 device clock, asynchronous, idle high.
REQ-006 ps2_dat  input  1  PS/2 device data, asynchronous, idle high.
REQ-007 kbmat  output  64  Z88 key matrix, 1=pressed, index = row*8+col, where row selects address line A(8+row).
REQ-008 kb_err  output  1  one-cycle pulse on any framing, parity or timeout error.
REQ-009 kb_vld  output  1  one-cycle pulse when a byte is received with good parity and framing.
REQ-010 kb_byte  output  8  last good received byte; holds its value between kb_vld pulses.

Function
REQ-011 ps2_clk and ps2_dat each pass through a 2-flop synchroniser; a falling edge is detected as synced-previous=1 and synced-current=0.
REQ-012 The receiver FSM has the states IDLE, DATA, PAR and STOP.
REQ-013 IDLE -> DATA on a falling edge with data=0 (start bit); on a falling edge with data=1 the receiver stays in IDLE and pulses kb_err.
REQ-014 DATA shifts 8 bits LSB first using a 3-bit counter; after the 8th bit it goes to PAR.
REQ-015 PAR samples the parity bit and goes to STOP.
REQ-016 Parity is odd: the XOR of 8 data bits and the parity bit shall equal 1.
REQ-017 STOP: on the falling edge with data=1 and good parity, the receiver pulses kb_vld on the next cycle (T+1) and updates kb_byte; it then returns to IDLE.
REQ-018 STOP with data=0 or bad parity pulses kb_err at T+1, discards the byte, and returns to IDLE.
REQ-019 Timeout counter: width TMO_BITS; cleared on every falling edge and while in IDLE; increments in any other state.
REQ-020 On timeout counter wrap to 0, the receiver goes to IDLE, pulses kb_err, and leaves kbmat unchanged.
REQ-021 The decoder FSM has the states NORM, BRK, EXT and EXTBRK, and advances only on kb_vld.
REQ-022 Decoder byte E0: NORM->EXT, and also BRK->EXTBRK (tolerant ordering).
REQ-023 Decoder byte F0: NORM->BRK, EXT->EXTBRK.
REQ-024 Byte AA (keyboard self-test pass) in any decoder state clears all 64 kbmat bits and returns the decoder to NORM.
REQ-025 Any other byte is looked up in a 256x7 table, with one table for normal codes and one for extended codes.
REQ-026 Table output bit6=1 means unmapped: the code is ignored and the decoder returns to NORM.
REQ-027 For a mapped code, bits[5:0] give the kbmat index.
REQ-028 A mapped code in state NORM or EXT sets the indexed kbmat bit; in BRK or EXTBRK it clears that bit.
REQ-029 After a mapped code the decoder returns to NORM.
REQ-030 kbmat updates at T+2 relative to the stop-bit edge cycle T; only the indexed bit changes.
REQ-031 The table is combinational from kb_byte plus the extension flag.
REQ-032 The following table entries are normative; all other entries are unmapped unless the keymap table defines them: normal 5A->6, 1C->45, 29->53, 12->54, 59->63; extended 75->3, 6B->4.
REQ-033 Repeated makes of a held key (typematic) leave an already-set bit set, with no toggle.
REQ-034 E1 and all other unmapped bytes produce no kbmat change and no error.
REQ-035 A break for an unpressed key is a no-op.
REQ-036 Only one kbmat bit is written per cycle; there are no simultaneous updates, because kb_vld pulses are at least 11 PS/2 edges apart.
REQ-037 The block never drives ps2_clk or ps2_dat; there is no host-to-device transmission.

Reset
REQ-038 While rin_n=0, the following hold asynchronously: kbmat=0, kb_err=0, kb_vld=0, kb_byte=00, both FSMs in IDLE/NORM, all counters 0, and synchroniser flops =1 (idle).
REQ-039 Reset asserted mid-frame abandons the frame; after release the receiver waits for a new start bit.
REQ-040 The first falling edge after release is a valid start bit only if it arrives with data=0.

Verification
REQ-041 Frame 1C with parity 0 -> kb_vld pulse at T+1, kb_byte=1C; kbmat=(1<<45) at T+2.
REQ-042 Frames F0,1C after REQ-041 -> kbmat=0; the decoder returns to NORM with no kb_err.
REQ-043 Frames E0,75 then E0,F0,75 -> bit3 set then cleared; the normal-map entry 75 is never written.
REQ-044 Frame 5A with a flipped parity bit -> kb_err pulse; kb_vld stays 0; kbmat unchanged.
REQ-045 4 data bits sent, then the line is held idle for 2^13+10 mck cycles -> a single kb_err pulse; the next full frame 29 sets bit53.
REQ-046 Keys 12 and 59 held, then byte AA -> kbmat=0; separately, rin_n pulsed low mid-frame -> kbmat=0 immediately, and the next frame decodes normally.
